mat_win3x3_gen: RTL and testbench

- Builds 3x3 pixel windows for PixelBox neighbourhood filters from a raster pixel stream.
- Uses two external prefetch line FIFOs (depth >= IMG_WIDTH) as row delays.
- Sits directly downstream of the line FIFOs: it drives their write and pop controls, consumes their show-ahead read data, and feeds a registered 9-pixel window to the filter core.

---
 rtl/mat_pkg.sv | 26 ++
 rtl/mat_tap_shift3.sv | 25 ++
 rtl/mat_win3x3_gen.sv | 164 ++++++++++++++++
 tb/tb_mat_win3x3_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared types and constants for the 3x3 window generator.
package mat_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL0 = 3'd1,
      ST_FILL1 = 3'd2,
      ST_RUN   = 3'd3,
      ST_FLUSH = 3'd4
   } mat_state_t;

   localparam int unsigned WIN_TAPS = 9;

   // Tap index of the rightmost pixel of each window row; a row spans 3 taps upward.
   localparam int unsigned WIN_ROW_TOP = 6;
   localparam int unsigned WIN_ROW_MID = 3;
   localparam int unsigned WIN_ROW_BOT = 0;

   // Underrun stall tolerated for this many row lengths before aborting the frame.
   localparam int unsigned STALL_MULT = 2;

   function automatic int unsigned win_w(input int unsigned dw);
      return WIN_TAPS * dw;
   endfunction

endpackage

// File: rtl/mat_tap_shift3.sv
// 3-stage pixel shift register; q = {oldest, middle, newest}.
// Shifts on en, 1-cycle latency per stage, no backpressure.
module mat_tap_shift3 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [DATA_WIDTH-1:0]     d,
   output logic [3*DATA_WIDTH-1:0]   q
);

   logic [3*DATA_WIDTH-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (en) begin
         sr <= {sr[2*DATA_WIDTH-1:0], d};
      end
   end

   assign q = sr;

endmodule

// File: rtl/mat_win3x3_gen.sv
// Builds registered 3x3 windows from a raster stream using two external line FIFOs as row delays.
// Window appears on the edge after the accepting edge; input stalls on FIFO space/underrun, output has no backpressure.
module mat_win3x3_gen
   import mat_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_vld,
   input  logic                               in_sof,
   input  logic [DATA_WIDTH-1:0]              in_data,
   output logic                               in_rdy,
   output logic                               fa_wr_en,
   output logic [DATA_WIDTH-1:0]              fa_wr_data,
   input  logic                               fa_wr_vld,
   output logic                               fa_rd_en,
   input  logic                               fa_rd_vld,
   input  logic [DATA_WIDTH-1:0]              fa_rd_data,
   output logic                               fb_wr_en,
   output logic [DATA_WIDTH-1:0]              fb_wr_data,
   input  logic                               fb_wr_vld,
   output logic                               fb_rd_en,
   input  logic                               fb_rd_vld,
   input  logic [DATA_WIDTH-1:0]              fb_rd_data,
   output logic                               out_vld,
   output logic [win_w(DATA_WIDTH)-1:0]       out_win,
   output logic                               out_last,
   output logic                               err_sync
);

   localparam int COL_W       = $clog2(IMG_WIDTH);
   localparam int ROW_W       = $clog2(IMG_HEIGHT);
   localparam int STALL_LIMIT = STALL_MULT * IMG_WIDTH;
   localparam int STALL_W     = $clog2(STALL_LIMIT);

   localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0]   ROW_PEN   = ROW_W'(IMG_HEIGHT - 2);
   localparam logic [STALL_W-1:0] STALL_END = STALL_W'(STALL_LIMIT - 1);

   mat_state_t          state_q, state_nxt;
   logic [COL_W-1:0]    col_q;
   logic [ROW_W-1:0]    row_q;
   logic [STALL_W-1:0]  stall_q;

   logic row_ge1, row_ge2, active, acc, proc, underrun, stall_to;
   logic col_end, row_end, err_set;
   logic win_ok_q, last_ok_q;

   logic [3*DATA_WIDTH-1:0] top_q, mid_q, bot_q;

   always_comb begin
      row_ge1  = (row_q != '0);
      row_ge2  = (row_q >= ROW_W'(2));
      active   = (state_q == ST_FILL0) || (state_q == ST_FILL1) || (state_q == ST_RUN);
      col_end  = (col_q == COL_LAST);
      row_end  = (row_q == ROW_LAST);

      // Gated by rst so every output reads 0 while reset is held.
      in_rdy   = !rst && (state_q != ST_FLUSH) && fa_wr_vld && fb_wr_vld
                 && (!row_ge1 || fa_rd_vld) && (!row_ge2 || fb_rd_vld);
      acc      = in_vld && in_rdy;
      proc     = acc && ((state_q == ST_IDLE) ? in_sof : (active && !in_sof));
      underrun = active && in_vld && ((row_ge1 && !fa_rd_vld) || (row_ge2 && !fb_rd_vld));
      stall_to = underrun && (stall_q == STALL_END);

      fa_wr_en   = proc && (row_q <= ROW_PEN);
      fb_wr_en   = proc && row_ge1 && (row_q <= ROW_PEN);
      fa_wr_data = fa_wr_en ? in_data : '0;
      fb_wr_data = fb_wr_en ? fa_rd_data : '0;
      fa_rd_en   = (state_q == ST_FLUSH) ? fa_rd_vld : (proc && row_ge1);
      fb_rd_en   = (state_q == ST_FLUSH) ? fb_rd_vld : (proc && row_ge2);

      state_nxt = state_q;
      err_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (proc) state_nxt = ST_FILL0;
         end
         ST_FILL0, ST_FILL1, ST_RUN: begin
            if ((acc && in_sof) || stall_to) begin
               state_nxt = ST_FLUSH;
               err_set   = 1'b1;
            end else if (proc && col_end) begin
               case (state_q)
                  ST_FILL0: state_nxt = ST_FILL1;
                  ST_FILL1: state_nxt = ST_RUN;
                  default:  state_nxt = row_end ? ST_IDLE : ST_RUN;
               endcase
            end
         end
         ST_FLUSH: begin
            if (!fa_rd_vld && !fb_rd_vld) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q    <= '0;
         row_q    <= '0;
         stall_q  <= '0;
         err_sync <= 1'b0;
      end else begin
         if (err_set) begin
            col_q <= '0;
            row_q <= '0;
         end else if (proc) begin
            if (col_end) begin
               col_q <= '0;
               row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         stall_q <= (underrun && !stall_to) ? stall_q + 1'b1 : '0;
         if (err_set) err_sync <= 1'b1;
      end
   end

   mat_tap_shift3 #(.DATA_WIDTH(DATA_WIDTH)) u_tap_top (
      .clk (clk), .rst (rst), .en (proc), .d (fb_rd_data), .q (top_q)
   );
   mat_tap_shift3 #(.DATA_WIDTH(DATA_WIDTH)) u_tap_mid (
      .clk (clk), .rst (rst), .en (proc), .d (fa_rd_data), .q (mid_q)
   );
   mat_tap_shift3 #(.DATA_WIDTH(DATA_WIDTH)) u_tap_bot (
      .clk (clk), .rst (rst), .en (proc), .d (in_data), .q (bot_q)
   );

   // Taps hold the complete window right after the accepting edge; capture it one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_ok_q  <= 1'b0;
         last_ok_q <= 1'b0;
         out_vld   <= 1'b0;
         out_last  <= 1'b0;
         out_win   <= '0;
      end else begin
         win_ok_q  <= proc && row_ge2 && (col_q >= COL_W'(2));
         last_ok_q <= proc && row_end && col_end;
         out_vld   <= win_ok_q;
         out_last  <= last_ok_q;
         if (win_ok_q) begin
            out_win[WIN_ROW_TOP*DATA_WIDTH +: 3*DATA_WIDTH] <= top_q;
            out_win[WIN_ROW_MID*DATA_WIDTH +: 3*DATA_WIDTH] <= mid_q;
            out_win[WIN_ROW_BOT*DATA_WIDTH +: 3*DATA_WIDTH] <= bot_q;
         end
      end
   end

endmodule

// File: tb/tb_mat_win3x3_gen.sv
// Directed bench for mat_win3x3_gen on a 4x4 frame with ideal show-ahead line FIFO models.
module tb_mat_win3x3_gen;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_vld = 1'b0, in_sof = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_rdy;
   logic          fa_wr_en, fa_rd_en, fb_wr_en, fb_rd_en;
   logic [DW-1:0] fa_wr_data, fb_wr_data, fa_rd_data, fb_rd_data;
   logic          fa_wr_vld = 1'b1, fb_wr_vld = 1'b1;
   logic          fa_rd_vld, fb_rd_vld;
   logic          out_vld, out_last, err_sync;
   logic [9*DW-1:0] out_win;

   always #5 clk = ~clk;

   mat_win3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data), .in_rdy(in_rdy),
      .fa_wr_en(fa_wr_en), .fa_wr_data(fa_wr_data), .fa_wr_vld(fa_wr_vld),
      .fa_rd_en(fa_rd_en), .fa_rd_vld(fa_rd_vld), .fa_rd_data(fa_rd_data),
      .fb_wr_en(fb_wr_en), .fb_wr_data(fb_wr_data), .fb_wr_vld(fb_wr_vld),
      .fb_rd_en(fb_rd_en), .fb_rd_vld(fb_rd_vld), .fb_rd_data(fb_rd_data),
      .out_vld(out_vld), .out_win(out_win), .out_last(out_last), .err_sync(err_sync)
   );

   // Show-ahead FIFO models; fa_hold forces an artificial underrun on FIFO A.
   logic [DW-1:0] qa[$], qb[$];
   logic          fa_have = 1'b0, fb_have = 1'b0, fa_hold = 1'b0;
   logic [DW-1:0] fa_head = '0, fb_head = '0;
   int            wa_cnt = 0;

   assign fa_rd_vld  = fa_have & ~fa_hold;
   assign fb_rd_vld  = fb_have;
   assign fa_rd_data = fa_head;
   assign fb_rd_data = fb_head;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (fa_rd_en && qa.size() > 0) void'(qa.pop_front());
         if (fb_rd_en && qb.size() > 0) void'(qb.pop_front());
         if (fa_wr_en) begin
            qa.push_back(fa_wr_data);
            wa_cnt++;
         end
         if (fb_wr_en) qb.push_back(fb_wr_data);
      end
      fa_have <= (qa.size() > 0);
      fb_have <= (qb.size() > 0);
      fa_head <= (qa.size() > 0) ? qa[0] : '0;
      fb_head <= (qb.size() > 0) ? qb[0] : '0;
   end

   logic [9*DW-1:0] win_q[$];
   logic            last_q[$];

   always @(negedge clk) begin
      if (out_vld) begin
         win_q.push_back(out_win);
         last_q.push_back(out_last);
      end
   end

   // Windows of the 4x4 frame whose pixels are 0..15, in raster order of their centres.
   logic [9*DW-1:0] exp_win [0:3] = '{
      72'h000102_040506_08090a,
      72'h010203_050607_090a0b,
      72'h040506_08090a_0c0d0e,
      72'h050607_090a0b_0d0e0f
   };

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic sof);
      bit took;
      took = 1'b0;
      @(negedge clk);
      in_vld = 1'b1; in_sof = sof; in_data = d;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (in_rdy) begin
            @(posedge clk);
            took = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!took) check("rdy_timeout", {71'd0, took}, 72'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_vld = 1'b0; in_sof = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < W*H; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) idle();
         drive(DW'(i), i == 0);
      end
      idle();
   endtask

   task automatic check_frame(input string tag);
      repeat (6) @(negedge clk);
      check({tag, "_nwin"}, win_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < win_q.size()) begin
            check({tag, "_win"}, win_q[i], exp_win[i]);
            check({tag, "_last"}, last_q[i], (i == 3));
         end
      end
      check({tag, "_fa_empty"}, qa.size(), 0);
      check({tag, "_fb_empty"}, qb.size(), 0);
      win_q.delete();
      last_q.delete();
   endtask

   task automatic stall_px(input logic [DW-1:0] d, input int ncyc);
      @(negedge clk);
      fa_hold = 1'b1; in_vld = 1'b1; in_sof = 1'b0; in_data = d;
      for (int n = 0; n < ncyc; n++) begin
         #1;
         check("stall_rdy", in_rdy, 0);
         @(negedge clk);
      end
      fa_hold = 1'b0; in_vld = 1'b0;
   endtask

   task automatic wait_rdy(input string tag);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_rdy) break;
      end
      check({tag, "_rdy_back"}, in_rdy, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_vld = 1'b0; in_sof = 1'b0; fa_hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      win_q.delete();
      last_q.delete();
   endtask

   int base;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_rdy", in_rdy, 0);
      check("rst_vld", out_vld, 0);
      check("rst_win", out_win, 0);
      check("rst_err", err_sync, 0);
      check("rst_fa_wr", fa_wr_en, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_rdy", in_rdy, 1);

      // Continuous frame
      send_frame(1'b0);
      check_frame("s1");
      check("s1_err", err_sync, 0);

      // Gapped frame
      send_frame(1'b1);
      check_frame("s2");

      // Pixels before any SOF are dropped
      base = wa_cnt;
      for (int k = 0; k < 3; k++) drive(DW'(8'hA0 + k), 1'b0);
      idle();
      @(negedge clk);
      check("s3_drop_wr", wa_cnt - base, 0);
      check("s3_drop_win", win_q.size(), 0);
      send_frame(1'b0);
      check_frame("s3");

      // Short FIFO A underrun in row 1 is absorbed
      for (int i = 0; i < 5; i++) drive(DW'(i), i == 0);
      stall_px(DW'(5), 5);
      for (int i = 5; i < W*H; i++) drive(DW'(i), 1'b0);
      idle();
      check_frame("s5a");
      check("s5a_err", err_sync, 0);

      // SOF at row 2, col 1 aborts the frame
      for (int i = 0; i < 9; i++) drive(DW'(i), i == 0);
      drive(DW'(9), 1'b1);
      idle();
      wait_rdy("s4");
      check("s4_err", err_sync, 1);
      check("s4_fa_empty", qa.size(), 0);
      check("s4_fb_empty", qb.size(), 0);
      check("s4_nwin", win_q.size(), 0);
      send_frame(1'b0);
      check_frame("s4");

      // Underrun lasting 2*W cycles raises err_sync and flushes
      do_reset();
      #1;
      check("s5b_rst_err", err_sync, 0);
      for (int i = 0; i < 5; i++) drive(DW'(i), i == 0);
      stall_px(DW'(5), 2*W);
      check("s5b_err", err_sync, 1);
      wait_rdy("s5b");
      check("s5b_fa_empty", qa.size(), 0);
      check("s5b_fb_empty", qb.size(), 0);

      // Reset mid row 3
      do_reset();
      for (int i = 0; i < 14; i++) drive(DW'(i), i == 0);
      @(negedge clk);
      rst = 1'b1; in_vld = 1'b0; in_sof = 1'b0;
      #1;
      check("s6_rdy", in_rdy, 0);
      check("s6_vld", out_vld, 0);
      check("s6_last", out_last, 0);
      check("s6_fa_wr", fa_wr_en, 0);
      check("s6_fa_rd", fa_rd_en, 0);
      check("s6_fb_rd", fb_rd_en, 0);
      check("s6_err", err_sync, 0);
      @(negedge clk);
      rst = 1'b0;
      win_q.delete();
      last_q.delete();
      send_frame(1'b0);
      check_frame("s6");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
